// File: rtl/rf_bypass_mp_if.sv
// Register-file access bundle: flattened read/write ports plus
// the conflict and sticky error status lines.
interface rf_bypass_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    logic [NREAD*ADDR_W-1:0]  read_sel;
    logic [NREAD*DATA_W-1:0]  read_data;
    logic [NWRITE-1:0]        write_en;
    logic [NWRITE*ADDR_W-1:0] write_sel;
    logic [NWRITE*DATA_W-1:0] write_data;
    logic                     conflict;
    logic                     err;

    modport master (
        output read_sel,
        output write_en,
        output write_sel,
        output write_data,
        input  read_data,
        input  conflict,
        input  err
    );

    modport slave (
        input  read_sel,
        input  write_en,
        input  write_sel,
        input  write_data,
        output read_data,
        output conflict,
        output err
    );
endinterface

// File: rtl/rf_bypass_mp.sv
// Parametrised multi-port register file with optional write-to-read
// bypass, optional hardwired zero register and sticky conflict flag.
module rf_bypass_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    rf_bypass_mp_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    generate
        if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
            $error("rf_bypass_mp: NREAD must be in 1..4");
        end
        if (NWRITE < 1 || NWRITE > 2) begin : g_bad_nwrite
            $error("rf_bypass_mp: NWRITE must be in 1..2");
        end
        if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
            $error("rf_bypass_mp: DATA_W and ADDR_W must be >= 1");
        end
    endgenerate

    logic [ADDR_W-1:0] w_wsel [NWRITE];
    logic [DATA_W-1:0] w_wdat [NWRITE];
    logic [NWRITE-1:0] w_wen;
    logic [NWRITE-1:0] w_wkeep;
    logic              w_conflict;

    logic [DATA_W-1:0] r_mem [NREG];
    logic              r_err;

    assign w_wen = bus.write_en;

    for (genvar w = 0; w < NWRITE; w++) begin : g_wr_unpack
        assign w_wsel[w] = bus.write_sel[w*ADDR_W +: ADDR_W];
        assign w_wdat[w] = bus.write_data[w*DATA_W +: DATA_W];
        // Writes aimed at a hardwired zero register never reach storage.
        assign w_wkeep[w] = w_wen[w]
                          & ~((ZERO_REG != 0) && (w_wsel[w] == '0));
    end

    generate
        if (NWRITE == 2) begin : g_conf2
            assign w_conflict = w_wen[0] & w_wen[1]
                              & (w_wsel[0] == w_wsel[1]);
        end else begin : g_conf1
            assign w_conflict = 1'b0;
        end
    endgenerate

    // Ports are applied in ascending order so the higher port wins a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (w_wkeep[w]) begin
                    r_mem[w_wsel[w]] <= w_wdat[w];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_conflict) begin
            r_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_rsel;
        logic [DATA_W-1:0] w_rval;

        assign w_rsel = bus.read_sel[i*ADDR_W +: ADDR_W];

        always_comb begin
            w_rval = r_mem[w_rsel];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (w_wen[w] && (w_wsel[w] == w_rsel)) begin
                        w_rval = w_wdat[w];
                    end
                end
            end
            if (!rst || ((ZERO_REG != 0) && (w_rsel == '0))) begin
                w_rval = '0;
            end
        end

        assign bus.read_data[i*DATA_W +: DATA_W] = w_rval;
    end

    assign bus.conflict = w_conflict;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_rf_bypass_mp.sv
// Directed plus randomized check of three rf_bypass_mp variants
// (bypass, no bypass, bypass with zero register) against a model.
module tb_rf_bypass_mp;
    logic        clk;
    logic        rst;
    logic [2:0]  rsel [2];
    logic [2:0]  wsel [2];
    logic [15:0] wdat [2];
    logic [1:0]  wen;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [3][8];
    bit          err_m;

    rf_bypass_mp_if ifb ();
    rf_bypass_mp_if ifn ();
    rf_bypass_mp_if ifz ();

    assign ifb.read_sel   = {rsel[1], rsel[0]};
    assign ifb.write_en   = wen;
    assign ifb.write_sel  = {wsel[1], wsel[0]};
    assign ifb.write_data = {wdat[1], wdat[0]};
    assign ifn.read_sel   = {rsel[1], rsel[0]};
    assign ifn.write_en   = wen;
    assign ifn.write_sel  = {wsel[1], wsel[0]};
    assign ifn.write_data = {wdat[1], wdat[0]};
    assign ifz.read_sel   = {rsel[1], rsel[0]};
    assign ifz.write_en   = wen;
    assign ifz.write_sel  = {wsel[1], wsel[0]};
    assign ifz.write_data = {wdat[1], wdat[0]};

    rf_bypass_mp #(.BYPASS(1), .ZERO_REG(0)) u_byp (
        .clk(clk), .rst(rst), .bus(ifb)
    );
    rf_bypass_mp #(.BYPASS(0), .ZERO_REG(0)) u_nob (
        .clk(clk), .rst(rst), .bus(ifn)
    );
    rf_bypass_mp #(.BYPASS(1), .ZERO_REG(1)) u_zro (
        .clk(clk), .rst(rst), .bus(ifz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Variant d: 0 = bypass, 1 = no bypass, 2 = bypass + zero register.
    function automatic logic [15:0] m_read(int d, logic [2:0] s);
        if (!rst) return 16'h0;
        if (d == 2 && s == 3'd0) return 16'h0;
        if (d != 1) begin
            if (wen[1] && wsel[1] == s) return wdat[1];
            if (wen[0] && wsel[0] == s) return wdat[0];
        end
        return mem[d][s];
    endfunction

    function automatic bit m_conf();
        return (wen == 2'b11) && (wsel[0] == wsel[1]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 8; k++) mem[d][k] = 16'h0;
        err_m = 1'b0;
    endtask

    task automatic commit();
        int win;
        if (!rst) return;
        win = -1;
        if (wen == 2'b11 && wsel[0] == wsel[1]) win = 1;
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 2; w++) begin
                if (!wen[w]) continue;
                if (win == 1 && w == 0) continue;
                if (d == 2 && wsel[w] == 3'd0) continue;
                mem[d][wsel[w]] = wdat[w];
            end
        end
        if (m_conf()) err_m = 1'b1;
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [31:0] rd [3];
        logic        cf [3];
        logic        er [3];
        rd[0] = ifb.read_data; cf[0] = ifb.conflict; er[0] = ifb.err;
        rd[1] = ifn.read_data; cf[1] = ifn.conflict; er[1] = ifn.err;
        rd[2] = ifz.read_data; cf[2] = ifz.conflict; er[2] = ifz.err;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++)
                chk($sformatf("%s d%0d rd%0d", tag, d, p),
                    rd[d][p*16 +: 16], m_read(d, rsel[p]));
            chk($sformatf("%s d%0d conflict", tag, d),
                {15'h0, cf[d]}, {15'h0, m_conf()});
            chk($sformatf("%s d%0d err", tag, d),
                {15'h0, er[d]}, {15'h0, err_m});
        end
    endtask

    task automatic step(string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        commit();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wen = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rsel[i] = 3'd0; wsel[i] = 3'd0; wdat[i] = 16'h0;
        end
        #1;
        rst = 1'b0;
        model_reset();

        for (int c = 0; c < 3; c++) begin
            wen = 2'b11;
            wsel[0] = 3'(c + 1);
            wsel[1] = (c == 2) ? 3'(c + 1) : 3'(c + 5);
            wdat[0] = 16'hA5A5 ^ 16'(c);
            wdat[1] = 16'h5A5A + 16'(c);
            rsel[0] = wsel[0];
            rsel[1] = wsel[1];
            step("in_reset");
        end

        wen = 2'b00;
        rst = 1'b1;
        for (int s = 0; s < 8; s += 2) begin
            rsel[0] = 3'(s);
            rsel[1] = 3'(s + 1);
            step("after_reset");
        end

        wen = 2'b01; wsel[0] = 3'd3; wdat[0] = 16'hBEEF;
        rsel[0] = 3'd3; rsel[1] = 3'd3;
        step("beef_wr");
        wen = 2'b00;
        step("beef_rd");

        wen = 2'b01; wsel[0] = 3'd5; wdat[0] = 16'h1234;
        rsel[0] = 3'd5; rsel[1] = 3'd4;
        step("byp_wr");
        wen = 2'b00;
        step("byp_rd");

        wen = 2'b11;
        wsel[0] = 3'd2; wdat[0] = 16'hAAAA;
        wsel[1] = 3'd2; wdat[1] = 16'h5555;
        rsel[0] = 3'd2; rsel[1] = 3'd2;
        step("conf_wr");
        wen = 2'b00;
        for (int c = 0; c < 11; c++) step("conf_hold");

        wen = 2'b01; wsel[0] = 3'd0; wdat[0] = 16'hFFFF;
        rsel[0] = 3'd0; rsel[1] = 3'd0;
        step("zero_wr");
        wen = 2'b00;
        step("zero_rd");

        for (int n = 0; n < 300; n++) begin
            wen = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                wsel[i] = 3'($urandom);
                wdat[i] = 16'($urandom);
            end
            for (int i = 0; i < 2; i++)
                rsel[i] = ($urandom_range(0, 1) == 0)
                        ? wsel[$urandom_range(0, 1)] : 3'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            step("rand");
        end

        rst = 1'b1;
        wen = 2'b01; wsel[0] = 3'd1; wdat[0] = 16'h00FF;
        rsel[0] = 3'd1; rsel[1] = 3'd6;
        step("mid_wr");
        wen = 2'b11;
        wsel[0] = 3'd6; wdat[0] = 16'h1111;
        wsel[1] = 3'd6; wdat[1] = 16'h2222;
        step("mid_conf");
        wen = 2'b00;
        rsel[0] = 3'd1; rsel[1] = 3'd1;
        #2;
        check_all("mid_pre");
        rst = 1'b0;
        model_reset();
        #1;
        check_all("mid_async");
        rst = 1'b1;
        @(posedge clk);
        commit();
        #1;
        step("mid_post");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_bypass_mp.md
Name: rf_bypass_mp

Overview:
- Parametrised multi-port register file with write-to-read bypass for the pipelined core's decode stage.
- Successor to the fixed 8x16, 2-read/1-write bypassed register file. Generalises:
  - data width and register count;
  - number of read ports and number of write ports;
  - selectable hardwired-zero register;
  - bypass that can be switched off;
  - write-conflict detection with a sticky error flag.
- Read paths are combinational. State updates on the rising clock edge.

Parameters:
- DATA_W, 16: register and data width in bits.
- ADDR_W, 3: register select width; the file holds 2**ADDR_W registers.
- NREAD, 2: number of read ports (1..4).
- NWRITE, 2: number of write ports (1..2).
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored contents only.
- ZERO_REG, 0: 1 = register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- read_sel  in  NREAD*ADDR_W  read selects, flattened; port i = bits [i*ADDR_W +: ADDR_W].
- read_data  out  NREAD*DATA_W  read data, flattened; port i = bits [i*DATA_W +: DATA_W].
- write_en  in  NWRITE  per-port write enable.
- write_sel  in  NWRITE*ADDR_W  write selects, flattened as for read_sel.
- write_data  in  NWRITE*DATA_W  write data, flattened as for read_data.
- conflict  out  1  combinational: both write ports enabled to the same register this cycle.
- err  out  1  sticky error flag, registered.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers clear to 0; err clears to 0;
  - while rst is low, read_data returns 0 on every port regardless of selects or bypass;
  - writes presented while rst is low are discarded;
  - deassertion takes effect at the next rising clk edge; there is no reset synchroniser inside the block.
- Write:
  - at a rising clk edge with rst high, every port w with write_en[w]=1 updates register write_sel[w] with write_data[w];
  - latency is 1 cycle to storage.
- Write conflict (NWRITE=2, both enables high, equal selects):
  - port 1 wins; port 0's data is dropped;
  - conflict=1 in that cycle;
  - err sets on that edge and holds until reset.
- conflict is tied 0 when NWRITE=1.
- ZERO_REG=1 and selected register is 0:
  - writes are discarded;
  - a conflict on register 0 is still flagged;
  - reads return 0, including through bypass.
- Read, BYPASS=1:
  - read_data[i] equals the write_data of the highest-index enabled write port whose write_sel matches read_sel[i];
  - if no write port matches, the stored value is returned;
  - purely combinational, zero cycles.
- Read, BYPASS=0:
  - read_data[i] is the stored value only;
  - a same-cycle write becomes visible the cycle after the edge.
- Multiple read ports selecting the same register all return identical data.
- err has no other set sources. Out-of-range selects cannot occur because the file size is 2**ADDR_W.
- Parameter checks at elaboration:
  - NREAD outside 1..4 or NWRITE outside 1..2 is a fatal error (generate-time $error);
  - DATA_W < 1 or ADDR_W < 1 is a fatal error.
- No internal pipelining. All outputs except err are combinational functions of inputs and storage.

Test Plan:
- Reset: hold rst low 3 cycles while driving write_en=2'b11 and assorted data → all reads 0, err=0. Release rst, read r0..r7 → all 0x0000.
- Basic write/read (BYPASS=0):
  - write port 0 puts 0xBEEF into r3 at edge N; read_sel[0]=3 shows old value 0x0000 in cycle N;
  - cycle N+1 shows 0xBEEF;
  - read_sel[1]=3 matches port 0.
- Bypass (BYPASS=1):
  - write port 0 puts 0x1234 into r5 while read_sel[0]=5 → read_data[0]=0x1234 in the same cycle;
  - read_sel[1]=4 is unaffected and returns its stored value.
- Dual-write conflict:
  - port 0 writes 0xAAAA and port 1 writes 0x5555, both to r2 → conflict=1 that cycle; bypassed read of r2 = 0x5555;
  - the next cycle stores 0x5555 and err=1;
  - err stays 1 through 10 idle cycles and clears only on rst low.
- Zero register (ZERO_REG=1): write 0xFFFF to r0 with read_sel=0 → read 0x0000 both that cycle and the next.
- Reset mid-operation: assert rst asynchronously mid-cycle after r1=0x00FF, err=1 → read_data=0 and err=0 immediately, without waiting for a clk edge; r1 reads 0 after release.
